ooo_commit_trace_buffer: RTL and testbench
==========================================

// Module: ooo_commit_trace_buffer
// PURPOSE
//  Parametrised commit-trace capture for the OOO core. Snoops up to NUM_CH ROB commit ports per cycle.
//  Stores records {seq, pc, instr, rd, wdata} in a DEPTH-entry circular buffer.
//  Supports wrap, stop-on-full and PC-trigger capture modes, with valid/ready readout once capture stops.
//  Sits beside the ROB and is fed from the commit side of the debug interface. Debug-only: it never
//  back-pressures the core.
// PARAMETERS
//  NUM_CH   2   commit channels sampled per cycle (1..4)
//  DEPTH    16  buffer entries; must be a power of 2, >= NUM_CH
//  XLEN     32  pc/instr/wdata width
//  SEQ_W    16  commit sequence-number width; wraps modulo 2^SEQ_W
// PORTS
//  clk           in   1                 core clock
//  reset_n       in   1                 synchronous, active-low reset
//  commit_valid  in   NUM_CH            per-channel commit strobe; channel 0 is oldest
//  commit_pc     in   NUM_CH x XLEN     committed pc
//  commit_instr  in   NUM_CH x XLEN     committed instruction word
//  commit_rd     in   NUM_CH x 5        destination register (0 = none)
//  commit_wdata  in   NUM_CH x XLEN     rd write data
//  flush_in_prog in   1                 ROB flush active; commits are ignored while high
//  cfg_mode      in   2                 0 WRAP, 1 STOP, 2 TRIG, 3 reserved (behaves as WRAP)
//  cfg_trig_pc   in   XLEN              trigger pc for TRIG mode
//  cfg_post_cnt  in   $clog2(DEPTH)     records to keep after the trigger record
//  arm           in   1                 start a new capture (pulse)
//  rd_valid      out  1                 rd_data holds the oldest record
//  rd_ready      in   1                 consumer accepts the record
//  rd_data       out  trace_rec_t       oldest record (combinational from head)
//  count         out  $clog2(DEPTH)+1   entries currently held
//  overflow_cnt  out  16                dropped/overwritten records, saturating
//  state_o       out  2                 IDLE=0 CAPTURE=1 POST=2 FROZEN=3
// BEHAVIOUR
//  Reset (reset_n=0 at a clk edge): state IDLE; head, tail, count, seq, overflow_cnt, post counter all 0.
//   rd_valid=0, rd_data=0. Reset mid-capture discards all contents.
//  FSM:
//   IDLE -arm-> CAPTURE. arm in any state restarts: clears head, tail, count, seq and overflow_cnt,
//    then enters CAPTURE next cycle. Commits in the arm cycle are not stored.
//   CAPTURE, WRAP mode: every commit is stored; the FSM never leaves CAPTURE unless re-armed or reset.
//    When full, each new record overwrites the oldest; head advances and overflow_cnt increments per overwrite.
//   CAPTURE, STOP mode: with k free slots and m>k valid channels, channels 0..k-1 are stored.
//    overflow_cnt += m-k. Once count reaches DEPTH -> FROZEN.
//   CAPTURE, TRIG mode: stores like WRAP. A valid channel j with commit_pc==cfg_trig_pc
//    (lowest j wins) is stored and loads post_rem=cfg_post_cnt.
//    Channels >j in the same cycle are stored and decrement post_rem; surplus is dropped.
//    Then -> POST, or -> FROZEN when post_rem reaches 0.
//   POST: stores (wrapping) and decrements post_rem per record; -> FROZEN when post_rem hits 0.
//    A later trigger match is ignored.
//   FROZEN: no stores. Commits still advance seq but are not counted as overflow.
//  Store ordering: valid channels are packed in ascending index into consecutive slots, all in one cycle.
//  seq: increments by popcount(commit_valid) in CAPTURE/POST when flush_in_prog=0.
//   Each record carries the seq of its own commit, so gaps in seq reveal dropped records.
//  flush_in_prog=1: all commit_valid are masked; no store, no seq advance.
//  Readout: rd_valid = (state==FROZEN || state==IDLE) && count!=0. rd_data is valid in the same cycle.
//   On rd_valid&&rd_ready, head++ and count-- at the edge. Pops while CAPTURE/POST are impossible.
//  Pointers: $clog2(DEPTH) bits, natural wrap. count is never > DEPTH. overflow_cnt saturates at 16'hFFFF.
//  Latency: a commit at edge N is visible in count after edge N; readable once FROZEN.
// STRUCTURE
//  Shared package (tomasula_types): trace_rec_t {seq[SEQ_W], pc, instr, rd[5], wdata},
//   trace_mode_t enum, trace_state_t enum.
//  Sub-module trace_ch_packer (combinational): valid mask + free slots + post_rem
//   -> per-channel write enable and slot offset, plus drop count.
//  Storage is a flop array (DEPTH x trace_rec_t); no SRAM macro.
// TESTING
//  1. Reset, arm, WRAP, NUM_CH=2, 20 single commits pc=0x100+4i -> count=16, head seq=4, overflow_cnt=4.
//  2. STOP, DEPTH=16: 15 single commits, then both channels valid -> ch0 stored, ch1 dropped,
//     FROZEN, overflow_cnt=1, 16 pops give seq 0..15.
//  3. TRIG, trig_pc=0x200, post_cnt=3: pc 0x1F0..0x220 step 4 -> FROZEN after pc 0x20C;
//     last record pc=0x20C, trigger at count-4.
//  4. Trigger on ch0 with ch1 valid and post_cnt=0 -> ch1 dropped, FROZEN next cycle, overflow_cnt+1.
//  5. flush_in_prog=1 during 3 commit cycles -> count and seq unchanged. rd_ready held high
//     while FROZEN -> one pop per cycle, rd_valid falls after the last.
//  6. reset_n=0 mid-POST -> next cycle state_o=0, count=0, rd_valid=0. arm mid-FROZEN -> contents cleared.

Source files
------------

// File: rtl/ooo_commit_trace_buffer_pkg.sv
// Shared types for the commit-trace buffer: record layout, capture modes and FSM states.
package ooo_commit_trace_buffer_pkg;

  localparam int unsigned TRACE_XLEN  = 32;
  localparam int unsigned TRACE_SEQ_W = 16;

  typedef struct packed {
    logic [TRACE_SEQ_W-1:0] seq;
    logic [TRACE_XLEN-1:0]  pc;
    logic [TRACE_XLEN-1:0]  instr;
    logic [4:0]             rd;
    logic [TRACE_XLEN-1:0]  wdata;
  } trace_rec_t;

  typedef enum logic [1:0] {
    MODE_WRAP = 2'd0,
    MODE_STOP = 2'd1,
    MODE_TRIG = 2'd2,
    MODE_RSVD = 2'd3
  } trace_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_POST    = 2'd2,
    ST_FROZEN  = 2'd3
  } trace_state_t;

  // The reserved encoding captures exactly like WRAP.
  function automatic trace_mode_t decode_mode(input logic [1:0] raw);
    case (raw)
      2'd1:    return MODE_STOP;
      2'd2:    return MODE_TRIG;
      default: return MODE_WRAP;
    endcase
  endfunction

endpackage

// File: rtl/ooo_commit_trace_buffer_packer.sv
// Packs valid commit channels into consecutive slots, storing at most 'limit' records per cycle.
module trace_ch_packer
  import ooo_commit_trace_buffer_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned LIM_W  = 6
) (
  input  logic [NUM_CH-1:0]            valid,
  input  logic [LIM_W-1:0]             limit,
  output logic [NUM_CH-1:0]            we,
  output logic [NUM_CH-1:0][LIM_W-1:0] offset,
  output logic [LIM_W-1:0]             n_store,
  output logic [LIM_W-1:0]             n_drop
);

  logic [LIM_W-1:0] rank;

  // offset is the rank among valid channels, which is also the seq delta of that commit.
  always_comb begin
    we      = '0;
    offset  = '0;
    n_store = '0;
    n_drop  = '0;
    rank    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      offset[i] = rank;
      if (valid[i]) begin
        if (rank < limit) begin
          we[i]   = 1'b1;
          n_store = n_store + LIM_W'(1);
        end else begin
          n_drop = n_drop + LIM_W'(1);
        end
        rank = rank + LIM_W'(1);
      end
    end
  end

endmodule

// File: rtl/ooo_commit_trace_buffer.sv
// Debug commit-trace capture: circular flop buffer with wrap, stop-on-full and PC-trigger modes.
module ooo_commit_trace_buffer
  import ooo_commit_trace_buffer_pkg::*;
#(
  parameter  int unsigned NUM_CH = 2,
  parameter  int unsigned DEPTH  = 16,
  parameter  int unsigned XLEN   = 32,
  parameter  int unsigned SEQ_W  = 16,
  localparam int unsigned PW     = $clog2(DEPTH),
  localparam int unsigned REC_W  = SEQ_W + 3*XLEN + 5
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_CH-1:0]            commit_valid,
  input  logic [NUM_CH-1:0][XLEN-1:0]  commit_pc,
  input  logic [NUM_CH-1:0][XLEN-1:0]  commit_instr,
  input  logic [NUM_CH-1:0][4:0]       commit_rd,
  input  logic [NUM_CH-1:0][XLEN-1:0]  commit_wdata,
  input  logic                         flush_in_prog,
  input  logic [1:0]                   cfg_mode,
  input  logic [XLEN-1:0]              cfg_trig_pc,
  input  logic [PW-1:0]                cfg_post_cnt,
  input  logic                         arm,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [REC_W-1:0]             rd_data,
  output logic [PW:0]                  count,
  output logic [15:0]                  overflow_cnt,
  output logic [1:0]                   state_o
);

  localparam int unsigned LIM_W = PW + 2;

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  instr;
    logic [4:0]       rd;
    logic [XLEN-1:0]  wdata;
  } rec_t;

  rec_t                            mem [DEPTH];
  trace_state_t                    state, state_next;
  trace_mode_t                     mode;
  logic [PW-1:0]                   head, tail, post_rem;
  logic [SEQ_W-1:0]                seq, seq_step;
  logic                            active, trig_hit, pop;
  logic [NUM_CH-1:0]               live, store_valid, we;
  logic [NUM_CH-1:0][LIM_W-1:0]    offset;
  logic [LIM_W-1:0]                limit, n_store, n_drop, free, over;
  logic [LIM_W-1:0]                trig_rank, scan_rank, post_next, count_next;
  logic [16:0]                     ovf_sum;

  assign mode = decode_mode(cfg_mode);

  always_comb begin
    live        = flush_in_prog ? '0 : commit_valid;
    active      = (state == ST_CAPTURE || state == ST_POST) && !arm;
    store_valid = active ? live : '0;
    seq_step    = (state != ST_IDLE && !arm) ? SEQ_W'($countones(live)) : '0;
    free        = LIM_W'(DEPTH) - LIM_W'(count);
  end

  // Rank of the trigger channel is recomputed here so it does not depend on the packer outputs.
  always_comb begin
    trig_hit  = 1'b0;
    trig_rank = '0;
    scan_rank = '0;
    if (state == ST_CAPTURE && mode == MODE_TRIG) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (store_valid[i]) begin
          if (!trig_hit && commit_pc[i] == cfg_trig_pc) begin
            trig_hit  = 1'b1;
            trig_rank = scan_rank;
          end
          scan_rank = scan_rank + LIM_W'(1);
        end
      end
    end
  end

  always_comb begin
    limit = '0;
    case (state)
      ST_CAPTURE: begin
        if (mode == MODE_STOP)
          limit = free;
        else if (trig_hit)
          limit = trig_rank + LIM_W'(1) + LIM_W'(cfg_post_cnt);
        else
          limit = LIM_W'(NUM_CH);
      end
      ST_POST: limit = LIM_W'(post_rem);
      default: limit = '0;
    endcase
  end

  trace_ch_packer #(
    .NUM_CH (NUM_CH),
    .LIM_W  (LIM_W)
  ) u_packer (
    .valid   (store_valid),
    .limit   (limit),
    .we      (we),
    .offset  (offset),
    .n_store (n_store),
    .n_drop  (n_drop)
  );

  // Records stored beyond the free space overwrite the oldest entries and push head forward.
  always_comb begin
    over       = (n_store > free) ? n_store - free : '0;
    count_next = LIM_W'(count) + n_store - over;
    ovf_sum    = {1'b0, overflow_cnt} + 17'(n_drop) + 17'(over);
    pop        = rd_valid && rd_ready;
    post_next  = LIM_W'(post_rem);
    if (trig_hit)
      post_next = LIM_W'(cfg_post_cnt) - (n_store - trig_rank - LIM_W'(1));
    else if (state == ST_POST)
      post_next = LIM_W'(post_rem) - n_store;
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (arm) begin
      state_next = ST_CAPTURE;
    end else begin
      case (state)
        ST_CAPTURE: begin
          if (trig_hit)
            state_next = (post_next == '0) ? ST_FROZEN : ST_POST;
          else if (mode == MODE_STOP && count_next == LIM_W'(DEPTH))
            state_next = ST_FROZEN;
        end
        ST_POST: if (post_next == '0) state_next = ST_FROZEN;
        default: state_next = state;
      endcase
    end
  end

  always_comb begin
    rd_valid = (state == ST_FROZEN || state == ST_IDLE) && count != '0;
    state_o  = state;
    rd_data  = rd_valid ? mem[head] : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n || arm) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      seq          <= '0;
      overflow_cnt <= '0;
      post_rem     <= '0;
    end else begin
      head         <= head + PW'(over) + PW'(pop);
      tail         <= tail + PW'(n_store);
      count        <= (PW+1)'(count_next) - (PW+1)'(pop);
      seq          <= seq + seq_step;
      overflow_cnt <= ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
      post_rem     <= PW'(post_next);
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (we[i])
        mem[tail + PW'(offset[i])] <= '{seq:   seq + SEQ_W'(offset[i]),
                                       pc:    commit_pc[i],
                                       instr: commit_instr[i],
                                       rd:    commit_rd[i],
                                       wdata: commit_wdata[i]};
    end
  end

endmodule

// File: tb/tb_ooo_commit_trace_buffer.sv
// Scoreboard bench: a per-record queue model predicts status and readout; a monitor compares.
module tb_ooo_commit_trace_buffer;
  import ooo_commit_trace_buffer_pkg::*;

  localparam int NCH = 2;
  localparam int DEP = 16;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic [NCH-1:0]            commit_valid;
  logic [NCH-1:0][31:0]      commit_pc, commit_instr, commit_wdata;
  logic [NCH-1:0][4:0]       commit_rd;
  logic                      flush_in_prog;
  logic [1:0]                cfg_mode;
  logic [31:0]               cfg_trig_pc;
  logic [3:0]                cfg_post_cnt;
  logic                      arm, rd_valid, rd_ready;
  logic [$bits(trace_rec_t)-1:0] rd_data;
  logic [4:0]                count;
  logic [15:0]               overflow_cnt;
  logic [1:0]                state_o;

  ooo_commit_trace_buffer #(
    .NUM_CH (NCH),
    .DEPTH  (DEP),
    .XLEN   (32),
    .SEQ_W  (16)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .commit_valid  (commit_valid),
    .commit_pc     (commit_pc),
    .commit_instr  (commit_instr),
    .commit_rd     (commit_rd),
    .commit_wdata  (commit_wdata),
    .flush_in_prog (flush_in_prog),
    .cfg_mode      (cfg_mode),
    .cfg_trig_pc   (cfg_trig_pc),
    .cfg_post_cnt  (cfg_post_cnt),
    .arm           (arm),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .rd_data       (rd_data),
    .count         (count),
    .overflow_cnt  (overflow_cnt),
    .state_o       (state_o)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int st;
    int cnt;
    int ovf;
    bit rv;
  } stat_t;

  stat_t       stat_q[$];
  trace_rec_t  exp_q[$];
  trace_rec_t  mbuf[$];
  int          mst = 0, mpost = 0, movf = 0;
  int unsigned mseq = 0;
  int          total = 0, bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic mdrop();
    if (movf < 65535) movf++;
  endtask

  task automatic mpush_wrap(input trace_rec_t r);
    mbuf.push_back(r);
    if (mbuf.size() > DEP) begin
      void'(mbuf.pop_front());
      mdrop();
    end
  endtask

  // Reference: each commit is handled in order as an individual record.
  task automatic model_update();
    int md;
    int st0;
    bit hit;
    trace_rec_t r;
    if (!reset_n || arm) begin
      mbuf.delete();
      mst = reset_n ? 1 : 0;
      mseq = 0; movf = 0; mpost = 0;
      return;
    end
    if ((mst == 0 || mst == 3) && mbuf.size() > 0 && rd_ready) void'(mbuf.pop_front());
    md  = (cfg_mode == 2'd3) ? 0 : int'(cfg_mode);
    st0 = mst;
    hit = 1'b0;
    if (mst != 0 && !flush_in_prog) begin
      for (int c = 0; c < NCH; c++) begin
        if (commit_valid[c]) begin
          r.seq   = 16'(mseq);
          r.pc    = commit_pc[c];
          r.instr = commit_instr[c];
          r.rd    = commit_rd[c];
          r.wdata = commit_wdata[c];
          mseq    = (mseq + 1) % 65536;
          if (st0 == 1 && md == 1) begin
            if (mbuf.size() < DEP) mbuf.push_back(r);
            else mdrop();
          end else if (st0 == 1 && md == 2 && !hit && r.pc == cfg_trig_pc) begin
            mpush_wrap(r);
            hit   = 1'b1;
            mpost = int'(cfg_post_cnt);
          end else if ((st0 == 1 && hit) || st0 == 2) begin
            if (mpost > 0) begin
              mpush_wrap(r);
              mpost--;
            end else begin
              mdrop();
            end
          end else if (st0 == 1) begin
            mpush_wrap(r);
          end
        end
      end
    end
    if (hit) mst = (mpost == 0) ? 3 : 2;
    else if (st0 == 2 && mpost == 0) mst = 3;
    else if (st0 == 1 && md == 1 && mbuf.size() == DEP) mst = 3;
  endtask

  // Called at a falling edge with inputs applied: queue expectations, advance model, wait one cycle.
  task automatic tick();
    stat_t s;
    s.st  = mst;
    s.cnt = mbuf.size();
    s.ovf = movf;
    s.rv  = (mst == 0 || mst == 3) && mbuf.size() > 0;
    stat_q.push_back(s);
    if (s.rv && rd_ready) exp_q.push_back(mbuf[0]);
    model_update();
    @(negedge clk);
  endtask

  initial forever begin
    stat_t s;
    trace_rec_t e;
    @(negedge clk);
    #2;
    if (stat_q.size() > 0) begin
      s = stat_q.pop_front();
      chk("state", 128'(state_o), 128'(s.st));
      chk("count", 128'(count), 128'(s.cnt));
      chk("overflow_cnt", 128'(overflow_cnt), 128'(s.ovf));
      chk("rd_valid", 128'(rd_valid), 128'(s.rv));
      if (!s.rv) chk("rd_data_zero", 128'(rd_data), '0);
    end
    if (rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        chk("pop_expected", 128'(exp_q.size()), 128'(1));
      end else begin
        e = exp_q.pop_front();
        chk("record", 128'(rd_data), 128'(e));
      end
    end
  end

  task automatic rnd_payload();
    for (int c = 0; c < NCH; c++) begin
      commit_instr[c] = $urandom;
      commit_rd[c]    = 5'($urandom);
      commit_wdata[c] = $urandom;
    end
  endtask

  task automatic commit1(input logic [31:0] pc);
    commit_valid = 2'b01;
    commit_pc[0] = pc;
    commit_pc[1] = $urandom;
    rnd_payload();
    tick();
    commit_valid = '0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic drain(input int n);
    rd_ready = 1'b1;
    idle(n);
    rd_ready = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; commit_valid = '0; commit_pc = '0; commit_instr = '0;
    commit_rd = '0; commit_wdata = '0; flush_in_prog = 1'b0; cfg_mode = 2'd0;
    cfg_trig_pc = 32'h200; cfg_post_cnt = 4'd3; arm = 1'b0; rd_ready = 1'b0;
    @(negedge clk);
    idle(3);
    reset_n = 1'b1;
    idle(2);

    // Wrap with 20 commits, then freeze the full buffer by switching to STOP.
    cfg_mode = 2'd0;
    do_arm();
    for (int i = 0; i < 20; i++) commit1(32'h100 + 32'(4 * i));
    cfg_mode = 2'd1;
    idle(2);
    drain(18);

    // Stop-on-full: last cycle has room for only channel 0.
    do_arm();
    for (int i = 0; i < 15; i++) commit1(32'h400 + 32'(4 * i));
    commit_valid = 2'b11; commit_pc[0] = 32'h500; commit_pc[1] = 32'h504; rnd_payload();
    tick();
    commit_valid = '0;
    idle(1);
    drain(18);

    // Trigger capture with three post-trigger records.
    cfg_mode = 2'd2; cfg_trig_pc = 32'h200; cfg_post_cnt = 4'd3;
    do_arm();
    for (int p = 32'h1F0; p <= 32'h220; p += 4) commit1(32'(p));
    drain(10);

    // Trigger on channel 0 with nothing left to keep after it.
    cfg_post_cnt = 4'd0;
    do_arm();
    commit1(32'h300);
    commit1(32'h304);
    commit_valid = 2'b11; commit_pc[0] = 32'h200; commit_pc[1] = 32'h308; rnd_payload();
    tick();
    commit_valid = '0;
    idle(1);
    drain(5);

    // Flushed commits leave no trace and no seq gap.
    cfg_mode = 2'd0;
    do_arm();
    for (int i = 0; i < 3; i++) commit1(32'h600 + 32'(4 * i));
    flush_in_prog = 1'b1;
    for (int i = 0; i < 3; i++) begin
      commit_valid = 2'b11; commit_pc[0] = 32'h200; commit_pc[1] = 32'h700; rnd_payload();
      tick();
    end
    flush_in_prog = 1'b0; commit_valid = '0;
    commit1(32'h610);
    commit1(32'h614);
    cfg_mode = 2'd2;
    commit1(32'h200);
    drain(8);

    // Reset during POST, then re-arm while frozen with contents.
    cfg_post_cnt = 4'd5;
    do_arm();
    commit1(32'h200);
    commit1(32'h204);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    idle(2);
    cfg_post_cnt = 4'd1;
    do_arm();
    commit1(32'h200);
    commit1(32'h204);
    idle(1);
    do_arm();
    idle(2);

    // Randomized traffic across all modes.
    cfg_trig_pc = 32'h200;
    for (int k = 0; k < 3000; k++) begin
      reset_n       = ($urandom_range(0, 199) != 0);
      arm           = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 19) == 0) cfg_post_cnt = 4'($urandom);
      if ($urandom_range(0, 29) == 0) cfg_mode = 2'($urandom);
      commit_valid  = 2'($urandom);
      for (int c = 0; c < NCH; c++)
        commit_pc[c] = ($urandom_range(0, 6) == 0) ? cfg_trig_pc : ($urandom & 32'hFFFC);
      rnd_payload();
      flush_in_prog = ($urandom_range(0, 9) == 0);
      rd_ready      = ($urandom_range(0, 9) < 6);
      tick();
    end
    reset_n = 1'b1; arm = 1'b0; commit_valid = '0; flush_in_prog = 1'b0; rd_ready = 1'b0;
    tick();
    #3;
    chk("exp_q_drained", 128'(exp_q.size()), '0);
    chk("stat_q_drained", 128'(stat_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
